pipeline_3_memacc: RTL

Memory-access stage of the 16-bit pipelined core, sitting between execute and the register-writeback stage. It registers the execute-stage control word, ALU result and store data, then issues LDR/STR accesses to the shared synchronous data RAM or to the memory-mapped LED/switch registers. When the RAM arbiter withholds a grant, it stalls upstream and sends bubbles downstream. Its outputs feed writeback directly: control and result are taken combinationally and registered by writeback, while read data arrives one cycle later, already registered.

---
 rtl/pipeline_3_memacc.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipeline_3_memacc.sv
// pipeline_3_memacc
// Memory-access stage of the 16-bit pipelined core. Registers the execute
// control word, ALU result and store data, then performs LDR/STR against the
// shared synchronous data RAM or the memory-mapped LED/switch registers.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   control_in   execute control word ([21:19] opcode, [3] we, [2:0] writenum)
//   result_in    ALU result, effective address for LDR/STR
//   sdata_in     store data for STR
//   mem_req/mem_we/mem_addr/mem_wdata   RAM request side
//   mem_gnt      arbiter grant
//   mem_rdata    registered RAM read data (cycle after a granted read)
//   sw_in        switch inputs
//   led_out      LED register
//   stall_out    hold request to upstream stages
//   control_out  control word to writeback (bubble while stalled)
//   result_out   result to writeback
//   rdata_out    load data to writeback, one cycle behind control_out
//
// Handshake: mem_req is a valid that stays asserted, with address/data/we
// stable, until the edge where mem_gnt is also high; that edge completes the
// access. mem_gnt acts as ready and may change freely while mem_req is low.

module pipeline_3_memacc (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] control_in,
  input  logic [15:0] result_in,
  input  logic [15:0] sdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic [15:0] mem_rdata,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  output logic        stall_out,
  output logic [21:0] control_out,
  output logic [15:0] result_out,
  output logic [15:0] rdata_out
);

  localparam logic [2:0] OP_LDR   = 3'b011;
  localparam logic [2:0] OP_STR   = 3'b100;
  localparam logic [8:0] ADDR_LED = 9'h100;
  localparam logic [8:0] ADDR_SW  = 9'h140;

  // Read-data source for the cycle after a load.
  localparam logic [1:0] SEL_RAM  = 2'd0;
  localparam logic [1:0] SEL_LED  = 2'd1;
  localparam logic [1:0] SEL_SW   = 2'd2;

  logic [21:0] ctl_q, ctl_d;
  logic [15:0] res_q, res_d;
  logic [15:0] sd_q,  sd_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_q,  sw_d;
  logic [1:0]  sel_q, sel_d;

  logic is_ldr, is_str, is_led, is_sw, is_mmio, stall;

  always_comb begin
    is_ldr  = (ctl_q[21:19] == OP_LDR);
    is_str  = (ctl_q[21:19] == OP_STR);
    is_led  = (res_q[8:0] == ADDR_LED);
    is_sw   = (res_q[8:0] == ADDR_SW);
    is_mmio = is_led || is_sw;
    mem_req = (is_ldr || is_str) && !is_mmio;
    stall   = mem_req && !mem_gnt;
  end

  always_comb begin
    // Instruction stays in the stage, unchanged, while the RAM withholds grant.
    ctl_d = stall ? ctl_q : control_in;
    res_d = stall ? res_q : result_in;
    sd_d  = stall ? sd_q  : sdata_in;

    // MMIO accesses never stall, so these updates land on the one edge the
    // instruction is in the stage.
    led_d = (is_str && is_led) ? sd_q[7:0] : led_q;
    sw_d  = (is_ldr && is_sw)  ? sw_in     : sw_q;

    // Remember where the load data will come from, since the address has
    // moved on by the time rdata_out is consumed.
    sel_d = SEL_RAM;
    if (is_ldr && is_sw)       sel_d = SEL_SW;
    else if (is_ldr && is_led) sel_d = SEL_LED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q <= '0;
      res_q <= '0;
      sd_q  <= '0;
      led_q <= '0;
      sw_q  <= '0;
      sel_q <= SEL_RAM;
    end else begin
      ctl_q <= ctl_d;
      res_q <= res_d;
      sd_q  <= sd_d;
      led_q <= led_d;
      sw_q  <= sw_d;
      sel_q <= sel_d;
    end
  end

  always_comb begin
    mem_we      = is_str;
    mem_addr    = res_q[8:0];
    mem_wdata   = sd_q;
    stall_out   = stall;
    led_out     = led_q;
    control_out = stall ? 22'b0 : ctl_q;
    result_out  = res_q;
    case (sel_q)
      SEL_SW:  rdata_out = {8'h00, sw_q};
      SEL_LED: rdata_out = 16'h0000;
      default: rdata_out = mem_rdata;
    endcase
  end

endmodule
